// File: rtl/out_channel_checker_if.sv
// Out-channel handshake between the executing program (master) and the checker (slave).
interface out_channel_checker_if #(
  parameter int W = 12
);
  logic         out_valid;
  logic [W-1:0] out_data;
  logic         out_ready;

  modport master (output out_valid, output out_data, input  out_ready);
  modport slave  (input  out_valid, input  out_data, output out_ready);
endinterface

// File: rtl/out_channel_checker.sv
// Streaming scorer for a test program's out channel: compares each accepted word
// against a preloaded table and reports finished/success/timeout like the harness.
module out_channel_checker #(
  parameter int MemoryElementWidth = 12,
  parameter int NOut               = 2,
  parameter int MaxSteps           = 8
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          exp_we,
  input  logic [$clog2(NOut):0]         exp_addr,
  input  logic [MemoryElementWidth-1:0] exp_data,
  input  logic                          start,
  out_channel_checker_if.slave          ch,
  output logic                          finished,
  output logic                          success,
  output logic                          timeout,
  output logic [$clog2(NOut):0]         received,
  output logic [$clog2(NOut):0]         mismatch_index,
  output logic [MemoryElementWidth-1:0] mismatch_data
);

  localparam int RW = $clog2(NOut) + 1;
  localparam int SW = $clog2(MaxSteps) + 1;
  localparam logic [RW-1:0] RCV_LAST  = RW'(NOut);
  localparam logic [SW-1:0] STEP_LAST = SW'(MaxSteps - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t                        r_state;
  logic [MemoryElementWidth-1:0] r_exp [NOut];
  logic [RW-1:0]                 r_received;
  logic [SW-1:0]                 r_steps;
  logic                          r_match;
  logic                          r_finished;
  logic                          r_success;
  logic                          r_timeout;
  logic [RW-1:0]                 r_mis_idx;
  logic [MemoryElementWidth-1:0] r_mis_data;

  logic [MemoryElementWidth-1:0] w_exp_cur;
  logic                          w_xfer;
  logic                          w_eq;
  logic [RW-1:0]                 w_rcv_next;

  // Expected value for the word about to be accepted (received < NOut while in RUN).
  always_comb begin
    w_exp_cur = '0;
    for (int i = 0; i < NOut; i++) begin
      if (r_received == RW'(i)) w_exp_cur = r_exp[i];
    end
  end

  assign w_xfer     = (r_state == S_RUN) && ch.out_valid;
  assign w_eq       = (ch.out_data == w_exp_cur);
  assign w_rcv_next = r_received + RW'(1);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_state    <= S_IDLE;
      r_received <= '0;
      r_steps    <= '0;
      r_match    <= 1'b0;
      r_finished <= 1'b0;
      r_success  <= 1'b0;
      r_timeout  <= 1'b0;
      r_mis_idx  <= '0;
      r_mis_data <= '0;
      for (int i = 0; i < NOut; i++) r_exp[i] <= '0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (exp_we) begin
            for (int i = 0; i < NOut; i++) begin
              if (exp_addr == RW'(i)) r_exp[i] <= exp_data;
            end
          end
          if (start) begin
            r_state    <= S_RUN;
            r_received <= '0;
            r_steps    <= '0;
            r_match    <= 1'b1;
            r_finished <= 1'b0;
            r_success  <= 1'b0;
            r_timeout  <= 1'b0;
            r_mis_idx  <= '0;
            r_mis_data <= '0;
          end
        end
        S_RUN: begin
          r_steps <= r_steps + SW'(1);
          if (w_xfer) begin
            r_received <= w_rcv_next;
            // Only the first mismatch is recorded.
            if (r_match && !w_eq) begin
              r_match    <= 1'b0;
              r_mis_idx  <= r_received;
              r_mis_data <= ch.out_data;
            end
          end
          // A completing transfer takes priority over the watchdog on the same cycle.
          if (w_xfer && (w_rcv_next == RCV_LAST)) begin
            r_state    <= S_DONE;
            r_finished <= 1'b1;
            r_success  <= r_match & w_eq;
          end else if (r_steps == STEP_LAST) begin
            r_state    <= S_DONE;
            r_finished <= 1'b1;
            r_timeout  <= 1'b1;
            r_success  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign ch.out_ready     = (r_state == S_RUN);
  assign finished         = r_finished;
  assign success          = r_success;
  assign timeout          = r_timeout;
  assign received         = r_received;
  assign mismatch_index   = r_mis_idx;
  assign mismatch_data    = r_mis_data;

endmodule

// File: tb/tb_out_channel_checker.sv
// Scoreboard bench for out_channel_checker: directed scenarios plus randomized runs.
module tb_out_channel_checker;

  localparam int W  = 12;
  localparam int N  = 2;
  localparam int MS = 8;
  localparam int RW = $clog2(N) + 1;
  localparam int PL = MS + 2;

  logic          clock;
  logic          reset_n;
  logic          exp_we;
  logic [RW-1:0] exp_addr;
  logic [W-1:0]  exp_data;
  logic          start;
  logic          finished;
  logic          success;
  logic          timeout;
  logic [RW-1:0] received;
  logic [RW-1:0] mismatch_index;
  logic [W-1:0]  mismatch_data;

  out_channel_checker_if #(.W(W)) ch ();

  out_channel_checker #(
    .MemoryElementWidth(W),
    .NOut(N),
    .MaxSteps(MS)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .exp_we(exp_we),
    .exp_addr(exp_addr),
    .exp_data(exp_data),
    .start(start),
    .ch(ch.slave),
    .finished(finished),
    .success(success),
    .timeout(timeout),
    .received(received),
    .mismatch_index(mismatch_index),
    .mismatch_data(mismatch_data)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    int       rcv;
    logic     succ;
    logic     to;
    int       mi;
    logic [W-1:0] md;
  } exp_t;

  exp_t         sb[$];
  exp_t         mon_e;
  logic         prev_fin;
  int           n_checks;
  int           n_pass;
  logic [W-1:0] m_exp [N];
  logic         pv [PL];
  logic [W-1:0] pd [PL];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, req);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic load(input int addr, input logic [W-1:0] data);
    exp_we   = 1'b1;
    exp_addr = RW'(addr);
    exp_data = data;
    tick();
    exp_we   = 1'b0;
    if (addr < N) m_exp[addr] = data;
  endtask

  // Reference: the run ends at the N-th word or at the last allowed cycle, whichever first.
  function automatic exp_t model();
    exp_t r;
    int   cnt;
    bit   ok;
    bit   done;
    cnt = 0; ok = 1; done = 0;
    r.rcv = 0; r.succ = 0; r.to = 0; r.mi = 0; r.md = '0;
    for (int c = 0; c < MS; c++) begin
      if (!done) begin
        if (pv[c]) begin
          if (ok && pd[c] != m_exp[cnt]) begin
            ok = 0; r.mi = cnt; r.md = pd[c];
          end
          cnt++;
          if (cnt == N) begin
            done = 1; r.succ = ok; r.to = 0;
          end
        end
        if (!done && c == MS - 1) begin
          done = 1; r.succ = 0; r.to = 1;
        end
      end
    end
    r.rcv = cnt;
    return r;
  endfunction

  task automatic run_plan(input string name);
    exp_t e;
    e = model();
    sb.push_back(e);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk({name, "_ready_run"}, ch.out_ready, 1);
    chk({name, "_cleared_fin"}, finished, 0);
    chk({name, "_cleared_rcv"}, received, 0);
    for (int c = 0; c < PL; c++) begin
      ch.out_valid = pv[c];
      ch.out_data  = pd[c];
      tick();
    end
    ch.out_valid = 1'b0;
    for (int i = 0; i < 20 && sb.size() != 0; i++) tick();
    if (sb.size() != 0) begin
      chk({name, "_no_finish"}, sb.size(), 0);
      sb.delete();
    end
    chk({name, "_ready_done"}, ch.out_ready, 0);
    chk({name, "_rcv_hold"}, received, e.rcv);
  endtask

  task automatic clear_plan();
    for (int c = 0; c < PL; c++) begin
      pv[c] = 1'b0;
      pd[c] = '0;
    end
  endtask

  always @(negedge clock) begin
    if (finished && !prev_fin) begin
      if (sb.size() == 0) chk("unexpected_finish", 1, 0);
      else begin
        mon_e = sb.pop_front();
        chk("sb_received", received, mon_e.rcv);
        chk("sb_success", success, mon_e.succ);
        chk("sb_timeout", timeout, mon_e.to);
        chk("sb_mis_index", mismatch_index, mon_e.mi);
        chk("sb_mis_data", mismatch_data, mon_e.md);
      end
    end
    prev_fin = finished;
  end

  initial begin
    int k;
    n_checks = 0; n_pass = 0; prev_fin = 1'b0;
    reset_n = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_data = '0; start = 1'b0;
    ch.out_valid = 1'b0; ch.out_data = '0;
    for (int i = 0; i < N; i++) m_exp[i] = '0;
    clear_plan();
    repeat (3) @(negedge clock);
    chk("rst_ready", ch.out_ready, 0);
    chk("rst_finished", finished, 0);
    chk("rst_success", success, 0);
    chk("rst_timeout", timeout, 0);
    chk("rst_received", received, 0);
    chk("rst_mis_index", mismatch_index, 0);
    chk("rst_mis_data", mismatch_data, 0);
    reset_n = 1'b1;
    tick();

    // Clean pass.
    load(0, 2); load(1, 1);
    clear_plan(); pv[0] = 1; pd[0] = 2; pv[1] = 1; pd[1] = 1;
    run_plan("pass");

    // First mismatch is kept; a later mismatch does not overwrite it.
    clear_plan(); pv[0] = 1; pd[0] = 1; pv[1] = 1; pd[1] = 5;
    run_plan("mismatch");

    // Only one word: watchdog ends the run.
    clear_plan(); pv[0] = 1; pd[0] = 2;
    run_plan("timeout");

    // Final word on the exact timeout cycle.
    clear_plan(); pv[0] = 1; pd[0] = 2; pv[MS-1] = 1; pd[MS-1] = 1;
    run_plan("edge");

    // Out-of-range address is ignored; reload and keep valid high into DONE.
    load(2, 12'h9); load(3, 12'h7); load(0, 5); load(1, 6);
    for (int c = 0; c < PL; c++) begin
      pv[c] = 1; pd[c] = (c == 0) ? 12'd5 : (c == 1) ? 12'd6 : 12'd7;
    end
    run_plan("reload");

    // Asynchronous reset mid-run.
    load(0, 2); load(1, 1);
    start = 1'b1; tick(); start = 1'b0;
    ch.out_valid = 1'b1; ch.out_data = 2; tick();
    ch.out_valid = 1'b0;
    chk("mid_rcv", received, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_ready", ch.out_ready, 0);
    chk("arst_received", received, 0);
    chk("arst_finished", finished, 0);
    for (int i = 0; i < N; i++) m_exp[i] = '0;
    @(negedge clock);
    reset_n = 1'b1;
    tick();
    clear_plan(); pv[0] = 1; pd[0] = 0; pv[1] = 1; pd[1] = 0;
    run_plan("after_rst");

    // Randomized runs.
    for (int r = 0; r < 25; r++) begin
      repeat ($urandom_range(0, 3)) load($urandom_range(0, 3), W'($urandom_range(0, 15)));
      k = 0;
      for (int c = 0; c < PL; c++) begin
        pv[c] = ($urandom_range(0, 2) != 0);
        if (k < N && $urandom_range(0, 3) != 0) pd[c] = m_exp[k];
        else pd[c] = W'($urandom_range(0, 15));
        if (pv[c]) k++;
      end
      run_plan("rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "bench time limit");
  end

endmodule
